// File: rtl/monitor_bus_master.sv
// monitor_bus_master: BKM option-slot bus initiator, one register access per request.
// Optional interrupt synchronizer is built only when MON_BUS_IRQ_EN is defined.
module monitor_bus_master #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic       clk_50mhz_in,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_init,
  input  logic [7:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       clk_rw,
  output logic       ax_d,
  output logic       r_wx,
  output logic       slot_int_x,
  output logic [7:0] bus_data_out_x,
  output logic       bus_data_oe,
  input  logic [7:0] bus_data_in,
  input  logic       int_x,
  output logic       irq
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_DEV  = 3'd2;
  localparam logic [2:0] S_REG  = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_END  = 3'd5;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  logic [2:0] state_q, state_d;
  logic       phase_q, phase_d;   // 0 = phase A (clk_rw low), 1 = phase B
  logic [7:0] cnt_q, cnt_d;
  logic       accept;

  logic       write_q, init_q;
  logic [7:0] dev_q, reg_q, wdata_q;
  logic       f_write, f_init;
  logic [7:0] f_dev, f_reg, f_wdata;

  logic [7:0] rdata_q, rdata_d;
  logic       rsp_valid_q, rsp_valid_d;

  logic       clk_rw_q, clk_rw_d;
  logic       ax_d_q, ax_d_d;
  logic       r_wx_q, r_wx_d;
  logic       slot_q, slot_d;
  logic [7:0] bus_x_q;
  logic [7:0] bus_d;
  logic       oe_q, oe_d;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    accept      = 1'b0;
    if (state_q == S_IDLE) begin
      if (cmd_valid) begin
        accept  = 1'b1;
        state_d = cmd_init ? S_DEV : S_SYNC;
        phase_d = 1'b0;
        cnt_d   = DIV_LOAD;
      end
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else if (!phase_q) begin
      phase_d = 1'b1;
      cnt_d   = DIV_LOAD;
      // Last clock before the clk_rw rise: card data has had a full half-period to settle.
      if (state_q == S_DATA && !write_q) begin
        rdata_d = bus_data_in;
      end
    end else begin
      phase_d = 1'b0;
      cnt_d   = DIV_LOAD;
      case (state_q)
        S_SYNC:  state_d = S_DEV;
        S_DEV:   state_d = S_REG;
        S_REG:   state_d = S_DATA;
        S_DATA:  state_d = S_END;
        default: begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
        end
      endcase
    end
  end

  assign f_write = accept ? cmd_write : write_q;
  assign f_init  = accept ? cmd_init  : init_q;
  assign f_dev   = accept ? cmd_dev   : dev_q;
  assign f_reg   = accept ? cmd_reg   : reg_q;
  assign f_wdata = accept ? cmd_wdata : wdata_q;

  // Bus drive is decoded from the next state so every output is a flop.
  always_comb begin
    clk_rw_d = 1'b1;
    ax_d_d   = 1'b0;
    r_wx_d   = 1'b1;
    bus_d    = 8'hFF;
    oe_d     = 1'b0;
    slot_d   = 1'b1;
    case (state_d)
      S_SYNC: begin
        clk_rw_d = phase_d;
        oe_d     = 1'b1;
      end
      S_DEV: begin
        clk_rw_d = phase_d;
        r_wx_d   = 1'b0;
        bus_d    = f_dev;
        oe_d     = 1'b1;
        slot_d   = ~f_init;
      end
      S_REG: begin
        clk_rw_d = phase_d;
        r_wx_d   = 1'b0;
        bus_d    = f_reg;
        oe_d     = 1'b1;
        slot_d   = ~f_init;
      end
      S_DATA: begin
        clk_rw_d = phase_d;
        ax_d_d   = 1'b1;
        r_wx_d   = ~f_write;
        bus_d    = f_write ? f_wdata : 8'hFF;
        oe_d     = f_write;
        slot_d   = ~f_init;
      end
      S_END: begin
        clk_rw_d = phase_d;
        oe_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50mhz_in) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      cnt_q       <= 8'd0;
      write_q     <= 1'b0;
      init_q      <= 1'b0;
      dev_q       <= 8'h00;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      clk_rw_q    <= 1'b1;
      ax_d_q      <= 1'b0;
      r_wx_q      <= 1'b1;
      slot_q      <= 1'b1;
      bus_x_q     <= 8'h00;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      write_q     <= f_write;
      init_q      <= f_init;
      dev_q       <= f_dev;
      reg_q       <= f_reg;
      wdata_q     <= f_wdata;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      clk_rw_q    <= clk_rw_d;
      ax_d_q      <= ax_d_d;
      r_wx_q      <= r_wx_d;
      slot_q      <= slot_d;
      bus_x_q     <= ~bus_d;
      oe_q        <= oe_d;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE) && !reset;
  assign busy           = (state_q != S_IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rdata_q;
  assign clk_rw         = clk_rw_q;
  assign ax_d           = ax_d_q;
  assign r_wx           = r_wx_q;
  assign slot_int_x     = slot_q;
  assign bus_data_out_x = bus_x_q;
  assign bus_data_oe    = oe_q;

`ifdef MON_BUS_IRQ_EN
  logic int_meta_q, int_sync_q;

  // Preset to the inactive level so irq stays low through reset and two clocks after.
  always_ff @(posedge clk_50mhz_in) begin
    if (reset) begin
      int_meta_q <= 1'b1;
      int_sync_q <= 1'b1;
    end else begin
      int_meta_q <= int_x;
      int_sync_q <= int_meta_q;
    end
  end

  assign irq = ~int_sync_q;
`else
  logic unused_int_x;

  assign unused_int_x = int_x;
  assign irq          = 1'b0;
`endif

endmodule

// File: doc/monitor_bus_master.md
# monitor_bus_master

Initiator side of the BKM option-slot bus: the slot responder already in the design is the target end. It turns single register-access requests from a host controller into the slot bus framing (clk_rw strobes, ax_d / r_wx qualifiers, inverted data bus). It returns read data from the option card. It is used as the monitor-side controller on the bench and in a standalone slot tester.

## Interface
- CLK_DIV, 25: system clocks per clk_rw half-period; legal 2..255 (25 → 1 MHz clk_rw at 50 MHz).

- clk_50mhz_in  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_init  in  1  1 = init-class access (slot select asserted, no leading sync).
- cmd_dev  in  8  device/command byte (e.g. 0x21 video, 0x20 ID, 0x10 init).
- cmd_reg  in  8  register byte.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data; held until next read completes.
- busy  out  1  high outside IDLE.
- clk_rw  out  1  bus strobe; target samples on rising edge.
- ax_d  out  1  0 = address/command phase, 1 = data phase.
- r_wx  out  1  1 = read, 0 = write.
- slot_int_x  out  1  active-low slot select for init-class access.
- bus_data_out_x  out  8  inverted bus data (card sees ~bus_data_out_x).
- bus_data_oe  out  1  master drives the bus.
- bus_data_in  in  8  card read data (true polarity).
- int_x  in  1  card interrupt, active low, asynchronous.
- irq  out  1  synchronized interrupt pending.

## Operation
- Request accepted on a cycle with cmd_valid && cmd_ready. Command fields are latched on that cycle.
- States: IDLE → [SYNC] → DEV → REG → DATA → END → IDLE. SYNC is skipped when cmd_init = 1.
- Each non-IDLE state is one bus cycle:
  - Phase A: clk_rw = 0 for CLK_DIV clocks. ax_d, r_wx, data and oe update on the first clock of phase A.
  - Phase B: clk_rw = 1 for CLK_DIV clocks.
- Per-state bus drive (ax_d / r_wx / bus / oe / slot_int_x):
  - SYNC: 0 / 1 / 0xFF / 1 / 1.
  - DEV: 0 / 0 / cmd_dev / 1 / (cmd_init ? 0 : 1).
  - REG: 0 / 0 / cmd_reg / 1 / same as DEV.
  - DATA write: 1 / 0 / cmd_wdata / 1 / same as DEV.
  - DATA read: 1 / 1 / 0xFF / 0 / same as DEV.
  - END: 0 / 1 / 0xFF / 1 / 1. This returns the target to its idle state.
- Bus values above are logical. bus_data_out_x always carries their bitwise complement.
- Read capture: bus_data_in is sampled into rsp_rdata on the last clock of DATA phase A, i.e. the clock before the clk_rw rise. A write leaves rsp_rdata unchanged.
- IDLE drive: clk_rw = 1, ax_d = 0, r_wx = 1, bus_data_out_x = 0x00 (logical 0xFF), bus_data_oe = 0, slot_int_x = 1.
- Half-period counter is 8 bits, loads CLK_DIV−1 and counts down. The phase toggles at 0.

## Timing
- Reset values: cmd_ready = 0 during reset and 1 on the first clock after it; rsp_valid = 0; rsp_rdata = 0x00; busy = 0; irq = 0; bus outputs at IDLE drive.
- Reset asserted mid-transaction:
  - Bus outputs return to IDLE drive on the next clock.
  - The request is dropped and no rsp_valid is produced.
- Latency with accept on clock T:
  - SYNC or DEV phase A starts at T+1.
  - rsp_valid pulses at T+1+10·CLK_DIV for a normal access.
  - rsp_valid pulses at T+1+8·CLK_DIV for an init access.
- rsp_valid coincides with the first IDLE clock.
  - cmd_ready is high in that same clock, so back-to-back accept is legal.
  - The next SYNC or DEV starts the clock after that.
- cmd_valid with cmd_ready low is ignored; the requester holds it.
- Setup from data change to clk_rw rise is CLK_DIV clocks. Hold after the rise is CLK_DIV clocks.

## Configuration
- MON_BUS_IRQ_EN defined:
  - int_x passes through a two-flop synchronizer.
  - irq = ~synchronized int_x, giving 2–3 clocks of latency.
  - irq is 0 during reset and for two clocks after it.
- MON_BUS_IRQ_EN undefined:
  - irq tied to 0.
  - int_x is unused and no synchronizer flops are built.

## Test plan
- Write video reg (CLK_DIV = 2, dev 0x21, reg 0x00, wdata 0x04, cmd_init = 0):
  - Bus shows, in order: FF(ax_d=0, r_wx=1), 21, 00 (ax_d=0, r_wx=0), 04 (ax_d=1, r_wx=0), FF end.
  - bus_data_out_x carries the complements DE, FB, FF.
  - rsp_valid at T+21; rsp_rdata unchanged.
- Read ID (dev 0x20, reg 0x00) against the slot responder model returning 0x88 → rsp_rdata = 0x88, bus_data_oe = 0 throughout DATA.
- Init write (cmd_init = 1, dev 0x10, reg 0x03, wdata 0x02):
  - No SYNC cycle.
  - slot_int_x low during DEV through DATA only.
  - rsp_valid at T+17 (CLK_DIV = 2).
- Reset during REG phase:
  - Next clock shows clk_rw = 1, bus_data_oe = 0, slot_int_x = 1.
  - No rsp_valid; cmd_ready = 1 after release.
- Back-to-back:
  - cmd_valid held high for two reads.
  - Second accept occurs in the rsp_valid clock of the first.
  - Exactly two rsp_valid pulses, 10·CLK_DIV+1 clocks apart.
- int_x toggle 1→0→1:
  - With MON_BUS_IRQ_EN, irq follows inverted within 3 clocks.
  - Without MON_BUS_IRQ_EN, irq stays 0.
